// File: rtl/qsfp_seq_pkg.sv
// Shared definitions for the QSFP port sequencer: state codes, counter width,
// status bit positions and the zero-means-one cycle helper.
package qsfp_seq_pkg;

    localparam int CNT_W = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ABSENT     = 3'd1;
    localparam state_t ST_REFCLK_RST = 3'd2;
    localparam state_t ST_MOD_RESET  = 3'd3;
    localparam state_t ST_MOD_INIT   = 3'd4;
    localparam state_t ST_READY      = 3'd5;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_PRESENT   = 3;
    localparam int STAT_INT       = 4;
    localparam int STAT_LPMODE    = 5;
    localparam int STAT_FS_LSB    = 6;

    // A zero-length phase still occupies one cycle so the FSM always advances.
    function automatic logic [CNT_W-1:0] cycle_limit(input logic [CNT_W-1:0] cycles);
        return (cycles == '0) ? CNT_W'(1) : cycles;
    endfunction

endpackage

// File: rtl/qsfp_sync_debounce.sv
// Two-flop synchronizer followed by a stability filter; CYCLES=0 leaves only
// the synchronizer so the level follows the input two cycles later.
module qsfp_sync_debounce
    import qsfp_seq_pkg::*;
#(
    parameter int unsigned CYCLES      = 4,
    parameter logic        RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level
);

    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {2{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    generate
        if (CYCLES == 0) begin : g_bypass
            assign level = sync_q[1];
        end else begin : g_debounce
            logic [CNT_W-1:0] stable_cnt;
            logic             stable_q;

            // A new level is accepted only after it has differed from the
            // current one for CYCLES consecutive samples.
            always_ff @(posedge clock) begin
                if (reset) begin
                    stable_q   <= RESET_VALUE;
                    stable_cnt <= '0;
                end else if (sync_q[1] == stable_q) begin
                    stable_cnt <= '0;
                end else if (stable_cnt >= CNT_W'(CYCLES - 1)) begin
                    stable_q   <= sync_q[1];
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end

            assign level = stable_q;
        end
    endgenerate

endmodule

// File: rtl/qsfp_port_sequencer.sv
// QSFP module power-up / reset sequencer. Define QSFP_SEQ_IRQ_EN to build the
// sticky event register behind irq; otherwise irq is tied low.
module qsfp_port_sequencer
    import qsfp_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned REFCLK_RST_CYCLES = 100000,
    parameter int unsigned MOD_RESET_CYCLES  = 1000,
    parameter int unsigned MOD_INIT_CYCLES   = 200000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       lp_req,
    input  logic [1:0] fs_sel,
    input  logic       qsfp_modprsl,
    input  logic       qsfp_intl,
    output logic       qsfp_modsell,
    output logic       qsfp_resetl,
    output logic       qsfp_lpmode,
    output logic       qsfp_refclk_reset,
    output logic [1:0] qsfp_fs,
    output logic       gt_reset,
    output logic       ready,
    output logic [7:0] status,
    output logic       irq,
    input  logic       irq_clear
);

    localparam logic [CNT_W-1:0] REFCLK_LIM  = cycle_limit(REFCLK_RST_CYCLES);
    localparam logic [CNT_W-1:0] MODRST_LIM  = cycle_limit(MOD_RESET_CYCLES);
    localparam logic [CNT_W-1:0] MODINIT_LIM = cycle_limit(MOD_INIT_CYCLES);

    logic             modprsl_db;
    logic             intl_sync;
    logic             present;
    logic             int_active;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_limit;
    logic             cnt_done;
    logic             load_fs;
    logic [1:0]       fs_q;
    logic [1:0]       fs_d;
    logic             lpmode_d;
    logic             resetl_q;
    logic             refclk_reset_q;
    logic             gt_reset_q;
    logic             ready_q;
    logic             modsell_q;
    logic [7:0]       status_q;

    qsfp_sync_debounce #(
        .CYCLES      (DEBOUNCE_CYCLES),
        .RESET_VALUE (1'b1)
    ) u_prs (
        .clock (clock),
        .reset (reset),
        .din   (qsfp_modprsl),
        .level (modprsl_db)
    );

    qsfp_sync_debounce #(
        .CYCLES      (0),
        .RESET_VALUE (1'b1)
    ) u_int (
        .clock (clock),
        .reset (reset),
        .din   (qsfp_intl),
        .level (intl_sync)
    );

    assign present    = ~modprsl_db;
    assign int_active = ~intl_sync;

    always_comb begin
        cnt_limit = CNT_W'(1);
        case (state_q)
            ST_REFCLK_RST: cnt_limit = REFCLK_LIM;
            ST_MOD_RESET:  cnt_limit = MODRST_LIM;
            ST_MOD_INIT:   cnt_limit = MODINIT_LIM;
            default:       cnt_limit = CNT_W'(1);
        endcase
        cnt_done = (cnt_q >= (cnt_limit - CNT_W'(1)));
    end

    // Disable beats removal, removal beats a refclk change or phase timeout.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       state_d = ST_ABSENT;
                ST_ABSENT:     if (present) state_d = ST_REFCLK_RST;
                ST_REFCLK_RST: if (!present) state_d = ST_ABSENT;
                               else if (cnt_done) state_d = ST_MOD_RESET;
                ST_MOD_RESET:  if (!present) state_d = ST_ABSENT;
                               else if (cnt_done) state_d = ST_MOD_INIT;
                ST_MOD_INIT:   if (!present) state_d = ST_ABSENT;
                               else if (cnt_done) state_d = ST_READY;
                ST_READY:      if (!present) state_d = ST_ABSENT;
                               else if (fs_sel != fs_q) state_d = ST_REFCLK_RST;
                default:       state_d = ST_IDLE;
            endcase
        end
        load_fs  = (state_d == ST_REFCLK_RST) && (state_q != ST_REFCLK_RST);
        fs_d     = load_fs ? fs_sel : fs_q;
        lpmode_d = ((state_d == ST_MOD_INIT) || (state_d == ST_READY)) ? lp_req : 1'b1;
    end

    // Pin outputs are registered from the next state so they change together
    // with the state code.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            fs_q           <= 2'b00;
            resetl_q       <= 1'b0;
            refclk_reset_q <= 1'b1;
            gt_reset_q     <= 1'b1;
            ready_q        <= 1'b0;
            modsell_q      <= 1'b1;
            status_q       <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            fs_q           <= fs_d;
            resetl_q       <= (state_d == ST_MOD_INIT) || (state_d == ST_READY);
            refclk_reset_q <= (state_d == ST_IDLE) || (state_d == ST_ABSENT) ||
                              (state_d == ST_REFCLK_RST);
            gt_reset_q     <= (state_d != ST_READY);
            ready_q        <= (state_d == ST_READY);
            modsell_q      <= (state_d != ST_READY);
            status_q[STAT_STATE_LSB +: 3] <= state_d;
            status_q[STAT_PRESENT]        <= present;
            status_q[STAT_INT]            <= int_active;
            status_q[STAT_LPMODE]         <= lpmode_d;
            status_q[STAT_FS_LSB +: 2]    <= fs_d;
        end
    end

    assign qsfp_lpmode       = ((state_q == ST_MOD_INIT) || (state_q == ST_READY)) ? lp_req : 1'b1;
    assign qsfp_resetl       = resetl_q;
    assign qsfp_refclk_reset = refclk_reset_q;
    assign qsfp_fs           = fs_q;
    assign gt_reset          = gt_reset_q;
    assign ready             = ready_q;
    assign qsfp_modsell      = modsell_q;
    assign status            = status_q;

`ifdef QSFP_SEQ_IRQ_EN
    logic       present_prev;
    logic       int_prev;
    logic [2:0] new_events;
    logic [2:0] events_q;

    assign new_events = {(state_q == ST_READY) && (state_d != ST_READY),
                         int_active & ~int_prev,
                         present ^ present_prev};

    // A clear only drops events already held; one arriving alongside it sticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            present_prev <= 1'b0;
            int_prev     <= 1'b0;
            events_q     <= 3'b000;
        end else begin
            present_prev <= present;
            int_prev     <= int_active;
            events_q     <= (irq_clear ? 3'b000 : events_q) | new_events;
        end
    end

    assign irq = |events_q;
`else
    logic unused_irq_clear;
    assign unused_irq_clear = irq_clear;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_qsfp_port_sequencer.sv
// Directed bench for qsfp_port_sequencer with short phase lengths; irq
// expectations collapse to 0 when QSFP_SEQ_IRQ_EN is not defined.
module tb_qsfp_port_sequencer;

    localparam int DEB    = 4;
    localparam int REFRST = 8;
    localparam int MODRST = 10;
    localparam int MODINI = 20;
`ifdef QSFP_SEQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       enable;
    logic       lp_req;
    logic [1:0] fs_sel;
    logic       qsfp_modprsl;
    logic       qsfp_intl;
    logic       qsfp_modsell;
    logic       qsfp_resetl;
    logic       qsfp_lpmode;
    logic       qsfp_refclk_reset;
    logic [1:0] qsfp_fs;
    logic       gt_reset;
    logic       ready;
    logic [7:0] status;
    logic       irq;
    logic       irq_clear;

    int n_checks = 0;
    int n_fail   = 0;

    qsfp_port_sequencer #(
        .DEBOUNCE_CYCLES   (DEB),
        .REFCLK_RST_CYCLES (REFRST),
        .MOD_RESET_CYCLES  (MODRST),
        .MOD_INIT_CYCLES   (MODINI)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .lp_req            (lp_req),
        .fs_sel            (fs_sel),
        .qsfp_modprsl      (qsfp_modprsl),
        .qsfp_intl         (qsfp_intl),
        .qsfp_modsell      (qsfp_modsell),
        .qsfp_resetl       (qsfp_resetl),
        .qsfp_lpmode       (qsfp_lpmode),
        .qsfp_refclk_reset (qsfp_refclk_reset),
        .qsfp_fs           (qsfp_fs),
        .gt_reset          (gt_reset),
        .ready             (ready),
        .status            (status),
        .irq               (irq),
        .irq_clear         (irq_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] irq_exp(input logic v);
        return {7'b0, v & IRQ_ON};
    endfunction

    function automatic logic [7:0] st(input logic [7:0] s);
        return {5'b0, s[2:0]};
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b0; lp_req = 1'b0; fs_sel = 2'd0;
        qsfp_modprsl = 1'b1; qsfp_intl = 1'b1; irq_clear = 1'b0;
        applyStimulus(3);
        checkOutput("rst_status", status, 8'h00);
        checkOutput("rst_pins", {qsfp_resetl, qsfp_refclk_reset, qsfp_lpmode, gt_reset, ready, qsfp_modsell, qsfp_fs},
                    8'b0111_0100);
        checkOutput("rst_irq", {7'b0, irq}, 8'h00);

        reset = 1'b0;
        applyStimulus(1);
        checkOutput("idle_status", status, 8'h20);
        enable = 1'b1;
        applyStimulus(1);
        checkOutput("absent_status", status, 8'h21);
        checkOutput("absent_irq", {7'b0, irq}, 8'h00);

        // Insertion: modprsl low first sampled on edge 0.
        qsfp_modprsl = 1'b0;
        for (int c = 0; c <= 44; c++) begin
            applyStimulus(1);
            case (c)
                5:  checkOutput("ins_c5_state", st(status), 8'd1);
                6:  checkOutput("ins_c6_refclk", {5'b0, st(status) == 8'd2, qsfp_refclk_reset, qsfp_resetl}, 8'b110);
                13: checkOutput("ins_c13_refclk", {7'b0, qsfp_refclk_reset}, 8'h01);
                14: checkOutput("ins_c14_modrst", {5'b0, st(status) == 8'd3, qsfp_refclk_reset, qsfp_resetl}, 8'b100);
                23: checkOutput("ins_c23_resetl", {7'b0, qsfp_resetl}, 8'h00);
                24: checkOutput("ins_c24_init", {5'b0, st(status) == 8'd4, qsfp_resetl, qsfp_lpmode}, 8'b110);
                43: checkOutput("ins_c43_ready", {6'b0, ready, gt_reset}, 8'b01);
                44: begin
                    checkOutput("ins_c44_ready", {5'b0, ready, gt_reset, qsfp_modsell}, 8'b100);
                    checkOutput("ins_c44_status", status, 8'h0D);
                    checkOutput("ins_c44_irq", {7'b0, irq}, irq_exp(1'b1));
                end
                default: ;
            endcase
        end

        lp_req = 1'b1;
        #1;
        checkOutput("ready_lpmode1", {7'b0, qsfp_lpmode}, 8'h01);
        lp_req = 1'b0;
        #1;
        checkOutput("ready_lpmode0", {7'b0, qsfp_lpmode}, 8'h00);

        // Interrupt with a clear coinciding with the latch edge.
        irq_clear = 1'b1;
        applyStimulus(1);
        irq_clear = 1'b0;
        checkOutput("int_pre_clear", {7'b0, irq}, 8'h00);
        qsfp_intl = 1'b0;
        applyStimulus(2);
        irq_clear = 1'b1;
        applyStimulus(1);
        irq_clear = 1'b0;
        checkOutput("int_same_clear_irq", {7'b0, irq}, irq_exp(1'b1));
        checkOutput("int_status", status, 8'h1D);
        applyStimulus(1);
        checkOutput("int_hold_irq", {7'b0, irq}, irq_exp(1'b1));
        irq_clear = 1'b1;
        applyStimulus(1);
        irq_clear = 1'b0;
        checkOutput("int_later_clear", {7'b0, irq}, 8'h00);
        qsfp_intl = 1'b1;
        applyStimulus(3);
        checkOutput("int_release_status", status, 8'h0D);

        // Refclk frequency change while READY.
        fs_sel = 2'd2;
        for (int c = 0; c <= 38; c++) begin
            applyStimulus(1);
            case (c)
                0: begin
                    checkOutput("fs_c0_pins", {3'b0, st(status) == 8'd2, qsfp_refclk_reset, ready, qsfp_fs}, 8'b11010);
                    checkOutput("fs_c0_irq", {7'b0, irq}, irq_exp(1'b1));
                end
                7:  checkOutput("fs_c7_refclk", {7'b0, qsfp_refclk_reset}, 8'h01);
                8:  checkOutput("fs_c8_refclk", {7'b0, qsfp_refclk_reset}, 8'h00);
                37: checkOutput("fs_c37_ready", {7'b0, ready}, 8'h00);
                38: checkOutput("fs_c38_ready", {5'b0, ready, qsfp_fs}, 8'b110);
                default: ;
            endcase
        end

        // Removal during MOD_INIT.
        fs_sel = 2'd0;
        applyStimulus(1);
        irq_clear = 1'b1;
        applyStimulus(1);
        irq_clear = 1'b0;
        checkOutput("rm_irq_cleared", {7'b0, irq}, 8'h00);
        applyStimulus(17);
        checkOutput("rm_in_init", st(status), 8'd4);
        qsfp_modprsl = 1'b1;
        for (int d = 0; d <= 6; d++) begin
            applyStimulus(1);
            if (d == 5) checkOutput("rm_d5_state", st(status), 8'd4);
            if (d == 6) begin
                checkOutput("rm_d6_pins", {4'b0, st(status) == 8'd1, qsfp_resetl, ready, 1'b0}, 8'b1000);
                checkOutput("rm_d6_irq", {7'b0, irq}, irq_exp(1'b1));
            end
        end

        // Short presence glitch while ABSENT.
        irq_clear = 1'b1;
        applyStimulus(1);
        irq_clear = 1'b0;
        qsfp_modprsl = 1'b0;
        applyStimulus(3);
        qsfp_modprsl = 1'b1;
        applyStimulus(10);
        checkOutput("glitch_state", st(status), 8'd1);
        checkOutput("glitch_irq", {7'b0, irq}, 8'h00);

        // Reset pulse in MOD_RESET, then disabled while present.
        qsfp_modprsl = 1'b0;
        applyStimulus(16);
        checkOutput("rp_in_modrst", st(status), 8'd3);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("rp_status", status, 8'h00);
        checkOutput("rp_pins", {qsfp_resetl, qsfp_refclk_reset, qsfp_lpmode, gt_reset, ready, qsfp_modsell, qsfp_fs},
                    8'b0111_0100);
        checkOutput("rp_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;
        enable = 1'b0;
        applyStimulus(20);
        checkOutput("dis_status", status, 8'h28);
        checkOutput("dis_irq", {7'b0, irq}, irq_exp(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qsfp_port_sequencer.md
QSFP_PORT_SEQUENCER -- requirements
Module: qsfp_port_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: cycles `modprsl` must be stable before a presence change is accepted.
REQ-002 SHALL have parameter REFCLK_RST_CYCLES, default 100000: cycles `qsfp_refclk_reset` is held after a `qsfp_fs` change.
REQ-003 SHALL have parameter MOD_RESET_CYCLES, default 1000: cycles `qsfp_resetl` is held low.
REQ-004 SHALL have parameter MOD_INIT_CYCLES, default 200000000: module init wait after reset release.
REQ-005 SHALL have the following ports:
- clock  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  port enable; 0 forces IDLE.
- lp_req  in  1  request module low-power mode.
- fs_sel  in  2  requested refclk frequency select.
- qsfp_modprsl  in  1  module present, active-low, asynchronous.
- qsfp_intl  in  1  module interrupt, active-low, asynchronous.
- qsfp_modsell  out  1  module select, active-low.
- qsfp_resetl  out  1  module reset, active-low.
- qsfp_lpmode  out  1  low-power mode.
- qsfp_refclk_reset  out  1  refclk synthesizer reset.
- qsfp_fs  out  2  refclk frequency select.
- gt_reset  out  1  GT/MAC reset; high unless READY.
- ready  out  1  port ready for traffic.
- status  out  8  [2:0] state code, [3] present, [4] int active, [5] lpmode, [7:6] fs.
- irq  out  1  event interrupt (see Configuration).
- irq_clear  in  1  single-cycle pulse clearing latched events.

Function
REQ-006 `qsfp_modprsl` and `qsfp_intl` SHALL each pass a 2-flop synchronizer; presence SHALL additionally be debounced; `int_active` is the synchronized inverse of `qsfp_intl`, not debounced.
REQ-007 State machine states and codes SHALL be: IDLE=0, ABSENT=1, REFCLK_RST=2, MOD_RESET=3, MOD_INIT=4, READY=5.
REQ-008 IDLE: resetl=0, refclk_reset=1, lpmode=1, gt_reset=1, ready=0. When `enable`=1, the FSM SHALL go to ABSENT on the next cycle.
REQ-009 ABSENT: the same outputs as IDLE. When debounced present=1, the FSM SHALL go to REFCLK_RST and latch `fs_sel` into `qsfp_fs`.
REQ-010 REFCLK_RST SHALL hold refclk_reset=1 for exactly REFCLK_RST_CYCLES cycles, then go to MOD_RESET.
REQ-011 MOD_RESET: refclk_reset=0, resetl=0; it SHALL last exactly MOD_RESET_CYCLES cycles, then go to MOD_INIT.
REQ-012 MOD_INIT: resetl=1; it SHALL last exactly MOD_INIT_CYCLES cycles, then go to READY.
REQ-013 READY: gt_reset=0 and ready=1, both registered and asserted in the first READY cycle.
REQ-014 `qsfp_lpmode` SHALL equal `lp_req` in MOD_INIT and READY, and SHALL be 1 in all other states.
REQ-015 `qsfp_modsell` SHALL be 1 except in READY, where it SHALL be 0.
REQ-016 Debounced present=0 in REFCLK_RST, MOD_RESET, MOD_INIT or READY SHALL go to ABSENT on the next cycle; the state counter SHALL clear.
REQ-017 `enable`=0 in any state SHALL go to IDLE on the next cycle, with priority over removal.
REQ-018 In READY, `fs_sel` != `qsfp_fs` SHALL go to REFCLK_RST and relatch `qsfp_fs`. In other states, `fs_sel` changes SHALL be ignored until the next ABSENT→REFCLK_RST transition.
REQ-019 The state counter SHALL be 32 bits, reload to 0 on every state entry, and never wrap. A parameter value of 0 SHALL be treated as 1 cycle.
REQ-020 With all parameters at their minimum, ready SHALL rise exactly 2+DEBOUNCE_CYCLES+REFCLK_RST_CYCLES+MOD_RESET_CYCLES+MOD_INIT_CYCLES cycles after a `qsfp_modprsl` falling edge seen while in ABSENT.

Reset
REQ-021 While `reset`=1, the FSM SHALL be in IDLE with IDLE outputs, fs=0, status=0x00, irq=0, synchronizers at the "absent / no interrupt" value, and counters=0.
REQ-022 `reset` asserted mid-sequence SHALL take effect on the next edge with no partial outputs.

Configuration
REQ-023 Macro QSFP_SEQ_IRQ_EN defined: the block SHALL latch sticky events (presence change, `int_active` rising, READY exit) and drive `irq` = OR of the events; `irq_clear` SHALL clear them. An event in the same cycle as `irq_clear` SHALL stay set.
REQ-024 Macro undefined: `irq` SHALL be tied to 0, `irq_clear` SHALL be ignored, and no event registers SHALL exist.

Structure
REQ-025 Package qsfp_seq_pkg SHALL hold the state enum with codes, the counter width constant (32), and the status bit-position constants.
REQ-026 Sub-module qsfp_sync_debounce (2-flop sync + stable counter, parameter CYCLES) SHALL be used for presence. Interrupt uses only its sync stage (CYCLES=0).

Verification (DEBOUNCE=4, REFCLK_RST=8, MOD_RESET=10, MOD_INIT=20)
REQ-027 enable=1, modprsl falls at cycle 0 → resetl low cycles 14–23, ready=1 and gt_reset=0 at cycle 44.
REQ-028 Module removed during MOD_INIT (modprsl=1 for 6 cycles) → ABSENT, resetl=0, ready=0, irq=1 (with macro).
REQ-029 In READY, fs_sel 0→2 → refclk_reset=1 for 8 cycles, qsfp_fs=2, ready returns after 38 cycles.
REQ-030 modprsl glitch low for 3 cycles in ABSENT → no state change, irq=0.
REQ-031 reset pulse in MOD_RESET → next cycle IDLE, status=0x00. Then enable=0 while present → remains IDLE.
REQ-032 intl falls in READY; irq_clear is pulsed on the same cycle the event is latched → irq stays 1; a later clear → irq=0; status[4] follows intl.
